// File: rtl/mux_pkg.sv
// Shared helpers for the one-hot mux pipeline: index width rule and one-hot decode.
// All functions take a select zero-extended to MAX_INPUTS bits.
package mux_pkg;

    localparam int MAX_INPUTS    = 32;
    localparam int MAX_IDX_WIDTH = 5;

    // Encoded index width; a 2-input mux still needs one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic onehot_legal(input logic [MAX_INPUTS-1:0] sel);
        int cnt;
        cnt = 0;
        for (int i = 0; i < MAX_INPUTS; i++) begin
            cnt += int'(sel[i]);
        end
        return (cnt == 1);
    endfunction

    function automatic logic [MAX_IDX_WIDTH-1:0] onehot_to_idx(input logic [MAX_INPUTS-1:0] sel);
        logic [MAX_IDX_WIDTH-1:0] idx;
        idx = '0;
        if (onehot_legal(sel)) begin
            for (int i = 0; i < MAX_INPUTS; i++) begin
                if (sel[i]) begin
                    idx = MAX_IDX_WIDTH'(i);
                end
            end
        end
        return idx;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/onehot_sel.sv
// Combinational one-hot selector: AND-OR data select, binary index and legality bit.
// Multi-hot selects OR channels together; the caller drops them via the legal bit.
module onehot_sel
    import mux_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_INPUTS = 5,
    parameter int IDX_WIDTH  = 3
) (
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] words,
    input  logic [NUM_INPUTS-1:0]            select,
    output logic [DATA_WIDTH-1:0]            data,
    output logic [IDX_WIDTH-1:0]             idx,
    output logic                             legal
);

    logic [MAX_INPUTS-1:0]    sel_ext;
    logic [MAX_IDX_WIDTH-1:0] idx_full;

    assign sel_ext  = MAX_INPUTS'(select);
    assign idx_full = onehot_to_idx(sel_ext);
    assign idx      = idx_full[IDX_WIDTH-1:0];
    assign legal    = onehot_legal(sel_ext);

    always_comb begin
        data = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            data = data | (words[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{select[k]}});
        end
    end

endmodule

// File: rtl/onehot_mux_pipe.sv
// One-hot selected N-input mux, registered output, 2-entry skid; 1-cycle latency.
// Back-pressure: oReady is the registered skid-empty flag, no path from iReady.
module onehot_mux_pipe
    import mux_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_INPUTS    = 5,
    parameter int IDX_WIDTH     = idx_width(NUM_INPUTS),
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] iData,
    input  logic [NUM_INPUTS-1:0]            select,
    input  logic                             iValid,
    output logic                             oReady,
    output logic [DATA_WIDTH-1:0]            oData,
    output logic [IDX_WIDTH-1:0]             oSelIdx,
    output logic                             oValid,
    input  logic                             iReady,
    input  logic                             iErrClr,
    output logic                             oErr,
    output logic [ERR_CNT_WIDTH-1:0]         errCount
);

    logic [DATA_WIDTH-1:0] sel_data;
    logic [IDX_WIDTH-1:0]  sel_idx;
    logic                  sel_legal;

    logic                  skid_vld;
    logic [DATA_WIDTH-1:0] skid_dat;
    logic [IDX_WIDTH-1:0]  skid_idx;

    logic in_fire;
    logic legal_fire;
    logic illegal_fire;
    logic out_free;

    onehot_sel #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_INPUTS (NUM_INPUTS),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_sel (
        .words  (iData),
        .select (select),
        .data   (sel_data),
        .idx    (sel_idx),
        .legal  (sel_legal)
    );

    assign oReady       = !skid_vld;
    assign in_fire      = iValid && oReady;
    assign legal_fire   = in_fire && sel_legal;
    assign illegal_fire = in_fire && !sel_legal;
    // Output register may take new data when it is empty or leaving this cycle.
    assign out_free     = !oValid || iReady;

    always_ff @(posedge clk) begin
        if (rst) begin
            oValid   <= 1'b0;
            oData    <= '0;
            oSelIdx  <= '0;
            skid_vld <= 1'b0;
            skid_dat <= '0;
            skid_idx <= '0;
        end else if (out_free) begin
            if (skid_vld) begin
                oValid   <= 1'b1;
                oData    <= skid_dat;
                oSelIdx  <= skid_idx;
                skid_vld <= 1'b0;
            end else if (legal_fire) begin
                oValid  <= 1'b1;
                oData   <= sel_data;
                oSelIdx <= sel_idx;
            end else begin
                oValid <= 1'b0;
            end
        end else if (legal_fire) begin
            skid_vld <= 1'b1;
            skid_dat <= sel_data;
            skid_idx <= sel_idx;
        end
    end

    // A clear coinciding with an illegal accept leaves exactly that one error recorded.
    always_ff @(posedge clk) begin
        if (rst) begin
            oErr     <= 1'b0;
            errCount <= '0;
        end else if (iErrClr) begin
            oErr     <= illegal_fire;
            errCount <= ERR_CNT_WIDTH'(illegal_fire);
        end else if (illegal_fire) begin
            oErr <= 1'b1;
            if (errCount != {ERR_CNT_WIDTH{1'b1}}) begin
                errCount <= errCount + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_onehot_mux_pipe.sv
// Directed bench for onehot_mux_pipe: reset, single transfer, skid back-pressure,
// scoreboarded streaming, illegal selects, counter saturation and mid-flight reset.
module tb_onehot_mux_pipe;

    localparam int DW = 32;
    localparam int N  = 5;
    localparam int IW = 3;
    localparam int CW = 8;

    logic            clk;
    logic            rst;
    logic [N*DW-1:0] iData;
    logic [N-1:0]    select;
    logic            iValid;
    logic            oReady;
    logic [DW-1:0]   oData;
    logic [IW-1:0]   oSelIdx;
    logic            oValid;
    logic            iReady;
    logic            iErrClr;
    logic            oErr;
    logic [CW-1:0]   errCount;

    int errors = 0;
    int checks = 0;

    onehot_mux_pipe #(
        .DATA_WIDTH    (DW),
        .NUM_INPUTS    (N),
        .ERR_CNT_WIDTH (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .iData    (iData),
        .select   (select),
        .iValid   (iValid),
        .oReady   (oReady),
        .oData    (oData),
        .oSelIdx  (oSelIdx),
        .oValid   (oValid),
        .iReady   (iReady),
        .iErrClr  (iErrClr),
        .oErr     (oErr),
        .errCount (errCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [DW-1:0] v);
        iData[k*DW +: DW] = v;
    endtask

    task automatic send(input int k, input logic [DW-1:0] v);
        iValid = 1'b1;
        select = N'(1) << k;
        set_ch(k, v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        iValid = 1'b0;
        iErrClr = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        iData = '0;
        select = '0;
        iReady = 1'b1;
        do_reset();
        checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL reset_ovalid got=%0b exp=0", oValid); end
        checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL reset_oready got=%0b exp=1", oReady); end
        checks++; if (oData !== 32'h0) begin errors++; $display("FAIL reset_odata got=%h exp=0", oData); end
        checks++; if (oSelIdx !== 3'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", oSelIdx); end
        checks++; if (oErr !== 1'b0 || errCount !== 8'd0) begin errors++; $display("FAIL reset_err got=%0b/%0d exp=0/0", oErr, errCount); end
    endtask

    task automatic test_single();
        for (int k = 0; k < N; k++) set_ch(k, 32'hA0A0_0000 + k);
        iReady = 1'b1;
        send(2, 32'hCAFE0002);
        step();
        iValid = 1'b0;
        checks++; if (oValid !== 1'b1) begin errors++; $display("FAIL single_ovalid got=%0b exp=1", oValid); end
        checks++; if (oData !== 32'hCAFE0002) begin errors++; $display("FAIL single_odata got=%h exp=cafe0002", oData); end
        checks++; if (oSelIdx !== 3'd2) begin errors++; $display("FAIL single_idx got=%0d exp=2", oSelIdx); end
        checks++; if (oErr !== 1'b0) begin errors++; $display("FAIL single_oerr got=%0b exp=0", oErr); end
        step();
        checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL single_drain got=%0b exp=0", oValid); end
    endtask

    task automatic test_backpressure();
        iReady = 1'b0;
        send(0, 32'h11);
        step();
        checks++; if (oValid !== 1'b1 || oData !== 32'h11 || oReady !== 1'b1) begin
            errors++; $display("FAIL bp_first got=v%0b d=%h r=%0b exp=v1 d=11 r=1", oValid, oData, oReady); end
        send(4, 32'h44);
        step();
        iValid = 1'b0;
        checks++; if (oReady !== 1'b0) begin errors++; $display("FAIL bp_full_oready got=%0b exp=0", oReady); end
        step();
        checks++; if (oData !== 32'h11 || oSelIdx !== 3'd0) begin errors++; $display("FAIL bp_hold got=%h/%0d exp=11/0", oData, oSelIdx); end
        iReady = 1'b1;
        step();
        checks++; if (oValid !== 1'b1 || oData !== 32'h44 || oSelIdx !== 3'd4) begin
            errors++; $display("FAIL bp_second got=v%0b %h/%0d exp=v1 44/4", oValid, oData, oSelIdx); end
        checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL bp_reopen got=%0b exp=1", oReady); end
        step();
        checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%0b exp=0", oValid); end
    endtask

    task automatic test_stream();
        logic [DW-1:0] exp_dat[$];
        logic [IW-1:0] exp_idx[$];
        logic [DW-1:0] held_dat;
        logic [IW-1:0] held_idx;
        logic          hold;
        int            sent;
        int            got;
        int            cyc;
        int            k;
        hold = 1'b0;
        held_dat = '0;
        held_idx = '0;
        sent = 0;
        got = 0;
        cyc = 0;
        while ((sent < 100 || got < 100) && cyc < 2000) begin
            if (hold) begin
                checks++; if (oData !== held_dat || oSelIdx !== held_idx) begin
                    errors++; $display("FAIL stream_stable got=%h/%0d exp=%h/%0d", oData, oSelIdx, held_dat, held_idx); end
            end
            iReady = 1'($urandom_range(0, 1));
            iValid = (sent < 100) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
            k = $urandom_range(0, N - 1);
            for (int c = 0; c < N; c++) set_ch(c, $urandom);
            select = N'(1) << k;
            if (oValid && iReady) begin
                checks++;
                if (exp_dat.size() == 0) begin
                    errors++; $display("FAIL stream_extra got=%h exp=none", oData);
                end else begin
                    if (oData !== exp_dat[0] || oSelIdx !== exp_idx[0]) begin
                        errors++; $display("FAIL stream_order got=%h/%0d exp=%h/%0d", oData, oSelIdx, exp_dat[0], exp_idx[0]);
                    end
                    void'(exp_dat.pop_front());
                    void'(exp_idx.pop_front());
                end
                got++;
            end
            if (iValid && oReady) begin
                exp_dat.push_back(iData[k*DW +: DW]);
                exp_idx.push_back(IW'(k));
                sent++;
            end
            hold = oValid && !iReady;
            held_dat = oData;
            held_idx = oSelIdx;
            step();
            cyc++;
        end
        iValid = 1'b0;
        iReady = 1'b1;
        checks++; if (got != 100 || exp_dat.size() != 0) begin
            errors++; $display("FAIL stream_count got=%0d left=%0d exp=100/0 (cycles=%0d)", got, exp_dat.size(), cyc); end
        step();
        step();
    endtask

    task automatic test_illegal();
        iReady = 1'b1;
        iValid = 1'b1;
        select = 5'b00000;
        step();
        select = 5'b00110;
        step();
        iValid = 1'b0;
        checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL illegal_emit got=%0b exp=0", oValid); end
        checks++; if (oErr !== 1'b1 || errCount !== 8'd2) begin errors++; $display("FAIL illegal_err got=%0b/%0d exp=1/2", oErr, errCount); end
        step();
        checks++; if (errCount !== 8'd2) begin errors++; $display("FAIL idle_no_count got=%0d exp=2", errCount); end
        iErrClr = 1'b1;
        step();
        iErrClr = 1'b0;
        checks++; if (oErr !== 1'b0 || errCount !== 8'd0) begin errors++; $display("FAIL errclr got=%0b/%0d exp=0/0", oErr, errCount); end
    endtask

    task automatic test_saturation();
        iReady = 1'b1;
        iValid = 1'b1;
        select = 5'b00000;
        for (int i = 0; i < 300; i++) step();
        checks++; if (errCount !== 8'd255) begin errors++; $display("FAIL sat_count got=%0d exp=255", errCount); end
        select = 5'b11000;
        iErrClr = 1'b1;
        step();
        iErrClr = 1'b0;
        iValid = 1'b0;
        checks++; if (oErr !== 1'b1 || errCount !== 8'd1) begin errors++; $display("FAIL clr_and_err got=%0b/%0d exp=1/1", oErr, errCount); end
        checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL sat_emit got=%0b exp=0", oValid); end
    endtask

    task automatic test_reset_midflight();
        iReady = 1'b0;
        send(1, 32'h0000_0B0B);
        step();
        send(3, 32'h0000_0D0D);
        step();
        iValid = 1'b0;
        checks++; if (oReady !== 1'b0 || oValid !== 1'b1) begin errors++; $display("FAIL mid_full got=r%0b v%0b exp=r0 v1", oReady, oValid); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (oValid !== 1'b0 || oReady !== 1'b1) begin errors++; $display("FAIL mid_rst_hs got=v%0b r%0b exp=v0 r1", oValid, oReady); end
        checks++; if (oData !== 32'h0 || errCount !== 8'd0 || oErr !== 1'b0) begin
            errors++; $display("FAIL mid_rst_state got=%h/%0d/%0b exp=0/0/0", oData, errCount, oErr); end
        iReady = 1'b1;
        step();
        checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL mid_rst_skid got=%0b exp=0", oValid); end
    endtask

    initial begin
        rst = 1'b1;
        iValid = 1'b0;
        iReady = 1'b0;
        iErrClr = 1'b0;
        iData = '0;
        select = '0;
        #1;
        test_reset();
        test_single();
        test_backpressure();
        test_stream();
        test_illegal();
        test_saturation();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
